// File: rtl/hv_memory_bank.sv
// Multi-channel hypervector memory: sliced single-port SRAMs, slice-serial load and a 2-entry read buffer.
// Read latency 2 cycles; loads take the slice port first, and rd_ready drops once buffer plus in-flight reads reach 2.
module hv_memory_bank #(
  parameter int HV_DIMENSION = 2000,
  parameter int SRAM_WIDTH   = 144,
  parameter int SRAM_DEPTH   = 32,
  parameter int NUM_CH       = 3,
  localparam int ADDR_W      = $clog2(SRAM_DEPTH),
  localparam int NUM_SLICES  = (HV_DIMENSION + SRAM_WIDTH - 1) / SRAM_WIDTH,
  localparam int LAST_WIDTH  = HV_DIMENSION - (NUM_SLICES - 1) * SRAM_WIDTH,
  localparam int SLICE_W     = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid,
  output logic                             load_ready,
  input  logic [CH_W-1:0]                  load_ch,
  input  logic [ADDR_W-1:0]                load_addr,
  input  logic [SLICE_W-1:0]               load_slice,
  input  logic [SRAM_WIDTH-1:0]            load_data,
  output logic                             load_err,
  input  logic                             rd_valid,
  output logic                             rd_ready,
  input  logic [NUM_CH*ADDR_W-1:0]         rd_addr,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [NUM_CH*HV_DIMENSION-1:0]   dout
);

  localparam int TW = NUM_CH * HV_DIMENSION;

  logic          rd_fire;
  logic          pop;
  logic          inflight;
  logic [1:0]    count;
  logic [1:0]    count_nxt;
  logic [2:0]    occ;
  logic          load_bad;
  logic [TW-1:0] q_all;
  logic [TW-1:0] head;
  logic [TW-1:0] head_nxt;
  logic [TW-1:0] tail;
  logic [TW-1:0] tail_nxt;

  assign load_ready = rst_n;
  assign pop        = dout_valid & dout_ready;
  // pop implies count >= 1, so the subtraction cannot wrap
  assign occ        = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign rd_ready   = rst_n & ~load_valid & (occ < 3'd2);
  assign rd_fire    = rd_valid & rd_ready;
  assign dout       = head;

  assign load_bad = load_valid &
                    (({1'b0, load_ch} >= (CH_W + 1)'(NUM_CH)) |
                     ({1'b0, load_slice} >= (SLICE_W + 1)'(NUM_SLICES)));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
      localparam int W = (s == NUM_SLICES - 1) ? LAST_WIDTH : SRAM_WIDTH;

      logic [W-1:0]      mem [SRAM_DEPTH];
      logic [W-1:0]      q;
      logic              we;
      logic [ADDR_W-1:0] addr;

      assign we   = load_valid & rst_n & (load_ch == CH_W'(c)) & (load_slice == SLICE_W'(s));
      assign addr = load_valid ? load_addr : rd_addr[c*ADDR_W +: ADDR_W];

      // Storage has no reset; Q only updates on an accepted read
      always_ff @(posedge clk) begin
        if (we) begin
          mem[addr] <= load_data[W-1:0];
        end else if (rd_fire) begin
          q <= mem[addr];
        end
      end

      assign q_all[c*HV_DIMENSION + s*SRAM_WIDTH +: W] = q;
    end
  end

  always_comb begin
    count_nxt = count;
    head_nxt  = head;
    tail_nxt  = tail;
    case (count)
      2'd0: begin
        if (inflight) begin
          head_nxt  = q_all;
          count_nxt = 2'd1;
        end
      end
      2'd1: begin
        if (inflight && pop) begin
          head_nxt = q_all;
        end else if (inflight) begin
          tail_nxt  = q_all;
          count_nxt = 2'd2;
        end else if (pop) begin
          count_nxt = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          head_nxt = tail;
          if (inflight) begin
            tail_nxt = q_all;
          end else begin
            count_nxt = 2'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight   <= 1'b0;
      count      <= 2'd0;
      dout_valid <= 1'b0;
      head       <= '0;
      tail       <= '0;
      load_err   <= 1'b0;
    end else begin
      inflight   <= rd_fire;
      count      <= count_nxt;
      dout_valid <= (count_nxt != 2'd0);
      head       <= head_nxt;
      tail       <= tail_nxt;
      if (load_bad) begin
        load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hv_memory_bank.sv
// Directed bench for hv_memory_bank with a reference table model and an expected-result queue.
module tb_hv_memory_bank;

  localparam int HV = 2000;
  localparam int SW = 144;
  localparam int D  = 32;
  localparam int NC = 3;
  localparam int AW = 5;
  localparam int NS = 14;
  localparam int LW = 128;
  localparam int SLW = 4;
  localparam int CW = 2;
  localparam int TW = NC * HV;

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [CW-1:0]    load_ch;
  logic [AW-1:0]    load_addr;
  logic [SLW-1:0]   load_slice;
  logic [SW-1:0]    load_data;
  logic             load_err;
  logic             rd_valid;
  logic             rd_ready;
  logic [NC*AW-1:0] rd_addr;
  logic             dout_valid;
  logic             dout_ready;
  logic [TW-1:0]    dout;

  hv_memory_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_addr  (load_addr),
    .load_slice (load_slice),
    .load_data  (load_data),
    .load_err   (load_err),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_addr    (rd_addr),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout       (dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [HV-1:0] model [NC][D];
  logic [TW-1:0] sb [$];
  int            acc_cyc [$];
  int            pop_cyc [$];

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    int fd;
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      fd = 0;
      for (int i = TW - 1; i >= 0; i--) if (obs[i] !== exp[i]) fd = i;
      $error("FAIL %s: observed %h required %h (first diff bit %0d)", tag,
             obs[(fd/SW)*SW +: SW], exp[(fd/SW)*SW +: SW], fd);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] pat(input int c, input int a, input int s);
    logic [10:0]  p;
    logic [153:0] r;
    p = {2'(c), 5'(a), 4'(s)};
    r = {14{p}};
    return r[SW-1:0];
  endfunction

  function automatic logic [TW-1:0] exp_for(input logic [NC*AW-1:0] a);
    logic [TW-1:0] e;
    for (int c = 0; c < NC; c++) e[c*HV +: HV] = model[c][int'(a[c*AW +: AW])];
    return e;
  endfunction

  // One clock: sample handshakes at the falling edge, then step past the rising edge
  task automatic cycle();
    logic [TW-1:0] e;
    int w;
    @(negedge clk);
    if (rd_valid && rd_ready) begin
      sb.push_back(exp_for(rd_addr));
      acc_cyc.push_back(cyc);
    end
    if (dout_valid && dout_ready) begin
      chk_int("sb_has_entry", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("dout", dout, e);
      end
      pop_cyc.push_back(cyc);
    end
    if (load_valid && load_ready && int'(load_ch) < NC && int'(load_slice) < NS) begin
      w = (int'(load_slice) == NS - 1) ? LW : SW;
      for (int i = 0; i < w; i++)
        model[int'(load_ch)][int'(load_addr)][int'(load_slice)*SW + i] = load_data[i];
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  initial begin
    int base_acc;
    int base_pop;
    logic [TW-1:0] held;
    logic [159:0]  rnd;

    rst_n = 1'b0; load_valid = 1'b0; load_ch = '0; load_addr = '0; load_slice = '0;
    load_data = '0; rd_valid = 1'b1; rd_addr = '0; dout_ready = 1'b1;
    #3;
    chk_int("reset_dout_valid", int'(dout_valid), 0);
    chk("reset_dout", dout, '0);
    chk_int("reset_rd_ready", int'(rd_ready), 0);
    chk_int("reset_load_ready", int'(load_ready), 0);
    chk_int("reset_load_err", int'(load_err), 0);
    rd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk_int("post_reset_load_ready", int'(load_ready), 1);
    chk_int("post_reset_rd_ready", int'(rd_ready), 1);

    // Fill every slice of every table
    load_valid = 1'b1;
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < D; a++)
        for (int s = 0; s < NS; s++) begin
          load_ch = CW'(c); load_addr = AW'(a); load_slice = SLW'(s);
          load_data = pat(c, a, s);
          cycle();
        end
    load_valid = 1'b0;
    chk_int("load_err_after_fill", int'(load_err), 0);

    // Sustained readback, a different address per channel
    base_acc = acc_cyc.size();
    base_pop = pop_cyc.size();
    rd_valid = 1'b1;
    for (int a = 0; a < D; a++) begin
      set_addr(a, (a + 1) % D, (a + 2) % D);
      cycle();
      chk_int("rb_accept_every_cycle", acc_cyc.size() - base_acc, a + 1);
    end
    rd_valid = 1'b0;
    repeat (4) cycle();
    chk_int("rb_result_count", pop_cyc.size() - base_pop, D);
    if (pop_cyc.size() - base_pop == D) begin
      chk_int("rb_first_latency", pop_cyc[base_pop] - acc_cyc[base_acc], 2);
      chk_int("rb_back_to_back", pop_cyc[base_pop + D - 1] - pop_cyc[base_pop], D - 1);
    end

    // Backpressure: only two requests fit, head holds
    dout_ready = 1'b0;
    rd_valid   = 1'b1;
    base_acc   = acc_cyc.size();
    held       = '0;
    for (int k = 0; k < 8; k++) begin
      set_addr((3*k) % D, (3*k + 7) % D, (3*k + 13) % D);
      cycle();
      if (k == 2) held = dout;
    end
    chk_int("bp_accepted", acc_cyc.size() - base_acc, 2);
    chk_int("bp_rd_ready_low", int'(rd_ready), 0);
    chk_int("bp_dout_valid", int'(dout_valid), 1);
    chk("bp_dout_stable", dout, held);
    rd_valid   = 1'b0;
    dout_ready = 1'b1;
    repeat (4) cycle();
    chk_int("bp_drained", sb.size(), 0);

    // Load/read collision, then read-after-write on the last (narrow) slice and a middle one
    for (int t = 0; t < 2; t++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rd_valid = 1'b1;
      set_addr(5, 5, 5);
      load_valid = 1'b1; load_ch = CW'(1); load_addr = AW'(5);
      load_slice = (t == 0) ? SLW'(3) : SLW'(NS - 1);
      load_data = rnd[SW-1:0];
      #1;
      chk_int("coll_rd_ready_low", int'(rd_ready), 0);
      base_acc = acc_cyc.size();
      cycle();
      chk_int("coll_no_accept", acc_cyc.size() - base_acc, 0);
      load_valid = 1'b0;
      #1;
      chk_int("coll_rd_ready_next", int'(rd_ready), 1);
      cycle();
      rd_valid = 1'b0;
      repeat (3) cycle();
      chk_int("coll_drained", sb.size(), 0);
    end

    // Out-of-range beats must not touch storage
    load_valid = 1'b1; load_ch = CW'(0); load_addr = AW'(0); load_slice = SLW'(NS);
    load_data = '1;
    cycle();
    chk_int("err_after_bad_slice", int'(load_err), 1);
    load_ch = CW'(3); load_slice = SLW'(0);
    cycle();
    chk_int("err_after_bad_ch", int'(load_err), 1);
    load_valid = 1'b0;
    rd_valid = 1'b1;
    set_addr(0, 0, 0);
    cycle();
    rd_valid = 1'b0;
    repeat (3) cycle();
    chk_int("err_sticky", int'(load_err), 1);
    chk_int("err_drained", sb.size(), 0);

    // Reset with results buffered and one read in flight
    dout_ready = 1'b0;
    rd_valid   = 1'b1;
    set_addr(1, 2, 3);
    cycle();
    set_addr(4, 5, 6);
    cycle();
    rd_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_int("midrst_dout_valid", int'(dout_valid), 0);
    chk("midrst_dout", dout, '0);
    chk_int("midrst_rd_ready", int'(rd_ready), 0);
    chk_int("midrst_load_ready", int'(load_ready), 0);
    chk_int("midrst_load_err", int'(load_err), 0);
    sb.delete();
    repeat (2) cycle();
    rst_n      = 1'b1;
    dout_ready = 1'b1;
    base_pop   = pop_cyc.size();
    repeat (5) cycle();
    chk_int("midrst_no_stale", pop_cyc.size() - base_pop, 0);
    chk_int("midrst_valid_low", int'(dout_valid), 0);

    chk_int("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
